// File: rtl/aes_nmr_pkg.sv
// rtl/aes_nmr_pkg.sv - shared types and constants for the N-modular-redundant AES top
// Purpose: FSM state and vote result enums, block width.
package aes_nmr_pkg;
  localparam int AES_BLK_W = 128;

  typedef enum logic [2:0] {IDLE, LAUNCH, RUN, CHECK, HOLD, LOCKED} state_t;
  typedef enum logic [1:0] {AGREE, CORRECTED, UNCORRECTABLE} vote_t;
endpackage

// File: rtl/aes128_core.sv
// rtl/aes128_core.sv - iterative AES-128 encryption core, one round per cycle
// Ports: start loads plaintext/key; done pulses one cycle when ciphertext is final;
//        busy high while rounds run; fault_inject flips ciphertext bit 0.
module aes128_core (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] plaintext,
  input  logic [127:0] key,
  input  logic         fault_inject,
  output logic         busy,
  output logic         done,
  output logic [127:0] ciphertext
);
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // S-box computed as GF(2^8) inverse (x^254) followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] p;
    logic [7:0] r;
    p = x;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] expand(input logic [127:0] rk, input logic [7:0] rcon);
    logic [31:0] t;
    logic [31:0] n0, n1, n2, n3;
    t  = {sbox(rk[23:16]), sbox(rk[15:8]), sbox(rk[7:0]), sbox(rk[31:24])} ^ {rcon, 24'h0};
    n0 = rk[127:96] ^ t;
    n1 = rk[95:64] ^ n0;
    n2 = rk[63:32] ^ n1;
    n3 = rk[31:0] ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  function automatic logic [127:0] round_fn(input logic [127:0] s, input logic last);
    logic [7:0]   b  [16];
    logic [7:0]   sr [16];
    logic [127:0] o;
    for (int i = 0; i < 16; i++) b[i] = sbox(s[127-8*i -: 8]);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) sr[r+4*c] = b[r+4*((c+r)%4)];
    for (int c = 0; c < 4; c++) begin
      if (last) begin
        for (int r = 0; r < 4; r++) o[127-8*(4*c+r) -: 8] = sr[4*c+r];
      end else begin
        o[127-32*c -: 8]  = xtime(sr[4*c]) ^ xtime(sr[4*c+1]) ^ sr[4*c+1] ^ sr[4*c+2] ^ sr[4*c+3];
        o[119-32*c -: 8]  = sr[4*c] ^ xtime(sr[4*c+1]) ^ xtime(sr[4*c+2]) ^ sr[4*c+2] ^ sr[4*c+3];
        o[111-32*c -: 8]  = sr[4*c] ^ sr[4*c+1] ^ xtime(sr[4*c+2]) ^ xtime(sr[4*c+3]) ^ sr[4*c+3];
        o[103-32*c -: 8]  = xtime(sr[4*c]) ^ sr[4*c] ^ sr[4*c+1] ^ sr[4*c+2] ^ xtime(sr[4*c+3]);
      end
    end
    return o;
  endfunction

  logic [127:0] state_q, state_d, rk_q, rk_d, rk_next;
  logic [7:0]   rcon_q, rcon_d;
  logic [3:0]   round_q, round_d;
  logic         busy_q, busy_d, done_q, done_d;

  always_comb begin
    state_d = state_q;
    rk_d    = rk_q;
    rcon_d  = rcon_q;
    round_d = round_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    rk_next = expand(rk_q, rcon_q);
    if (start) begin
      state_d = plaintext ^ key;
      rk_d    = key;
      rcon_d  = 8'h01;
      round_d = 4'd1;
      busy_d  = 1'b1;
    end else if (busy_q) begin
      state_d = round_fn(state_q, round_q == 4'd10) ^ rk_next;
      rk_d    = rk_next;
      rcon_d  = xtime(rcon_q);
      round_d = round_q + 4'd1;
      if (round_q == 4'd10) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= '0;
      rk_q    <= '0;
      rcon_q  <= '0;
      round_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rk_q    <= rk_d;
      rcon_q  <= rcon_d;
      round_q <= round_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign ciphertext = state_q ^ {127'b0, fault_inject};
endmodule

// File: rtl/aes_nmr_voter.sv
// rtl/aes_nmr_voter.sv - combinational compare / majority voter over lane ciphertexts
// Ports: lane_ct (NUM_LANES blocks) in; vote class and selected result out.
module aes_nmr_voter
  import aes_nmr_pkg::*;
#(
  parameter int NUM_LANES = 3
) (
  input  logic [NUM_LANES-1:0][AES_BLK_W-1:0] lane_ct,
  output vote_t                               vote,
  output logic [AES_BLK_W-1:0]                result
);
  if (NUM_LANES == 3) begin : g_tmr
    always_comb begin
      vote   = UNCORRECTABLE;
      result = lane_ct[0];
      if (lane_ct[0] == lane_ct[1] && lane_ct[1] == lane_ct[2]) begin
        vote = AGREE;
      end else if (lane_ct[0] == lane_ct[1] || lane_ct[0] == lane_ct[2]) begin
        vote = CORRECTED;
      end else if (lane_ct[1] == lane_ct[2]) begin
        vote   = CORRECTED;
        result = lane_ct[1];
      end
    end
  end else begin : g_dmr
    always_comb begin
      result = lane_ct[0];
      vote   = (lane_ct[0] == lane_ct[1]) ? AGREE : UNCORRECTABLE;
    end
  end
endmodule

// File: rtl/power_noise.sv
// rtl/power_noise.sv - LFSR-driven switching activity generator
// Ports: enable runs the LFSR, otherwise it reloads from seed; activity is its output bit.
module power_noise (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [31:0] seed,
  output logic        activity
);
  logic [31:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = seed | 32'h1;  // never load the all-zero lock-up state
    if (enable) lfsr_d = {lfsr_q[30:0], lfsr_q[31] ^ lfsr_q[21] ^ lfsr_q[1] ^ lfsr_q[0]};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) lfsr_q <= 32'h1;
    else        lfsr_q <= lfsr_d;
  end

  assign activity = enable & lfsr_q[0];
endmodule

// File: rtl/aes128_nmr_top.sv
// rtl/aes128_nmr_top.sv - redundant AES-128 top with voting, retry and fault lockout
// Ports: in_valid/in_ready + plaintext/key request; out_valid/out_ready + ciphertext
//        response; inject_fault per lane; corrected, fault_alert, locked, busy,
//        fault_count and noise_activity status.
module aes128_nmr_top
  import aes_nmr_pkg::*;
#(
  parameter int NUM_LANES   = 3,
  parameter int RETRY_MAX   = 2,
  parameter int FAULT_LIMIT = 8,
  parameter int TIMEOUT_CYC = 64,
  parameter int CNT_W       = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [AES_BLK_W-1:0] plaintext,
  input  logic [AES_BLK_W-1:0] key,
  input  logic [NUM_LANES-1:0] inject_fault,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [AES_BLK_W-1:0] ciphertext,
  output logic                 corrected,
  output logic                 fault_alert,
  output logic                 locked,
  output logic                 busy,
  output logic [CNT_W-1:0]     fault_count,
  output logic                 noise_activity
);
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam int RTW   = $clog2(RETRY_MAX + 2);

  state_t                             state_q, state_d;
  logic [AES_BLK_W-1:0]               pt_q, pt_d, key_q, key_d, result_q, result_d;
  logic [NUM_LANES-1:0]               done_lat_q, done_lat_d;
  logic [NUM_LANES-1:0][AES_BLK_W-1:0] ct_lat_q, ct_lat_d, lane_ct;
  logic [TMO_W-1:0]                   tmo_q, tmo_d;
  logic [RTW-1:0]                     retry_q, retry_d;
  logic [CNT_W-1:0]                   cnt_q, cnt_d;
  logic                               corr_q, corr_d, alert_q, fault_ev, uncorr;
  logic [NUM_LANES-1:0]               lane_busy, lane_done;
  vote_t                              vote;
  logic [AES_BLK_W-1:0]               vote_result;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    aes128_core u_core (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (state_q == LAUNCH),
      .plaintext    (pt_q),
      .key          (key_q),
      .fault_inject (inject_fault[i]),
      .busy         (lane_busy[i]),
      .done         (lane_done[i]),
      .ciphertext   (lane_ct[i])
    );
  end

  aes_nmr_voter #(.NUM_LANES(NUM_LANES)) u_voter (
    .lane_ct (ct_lat_q),
    .vote    (vote),
    .result  (vote_result)
  );

  power_noise u_noise (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (busy),
    .seed     (key_q[31:0] ^ pt_q[127:96]),
    .activity (noise_activity)
  );

  always_comb begin
    state_d    = state_q;
    pt_d       = pt_q;
    key_d      = key_q;
    result_d   = result_q;
    done_lat_d = done_lat_q;
    ct_lat_d   = ct_lat_q;
    tmo_d      = tmo_q;
    retry_d    = retry_q;
    cnt_d      = cnt_q;
    corr_d     = corr_q;
    fault_ev   = 1'b0;
    uncorr     = 1'b0;
    case (state_q)
      IDLE: if (in_valid) begin
        pt_d    = plaintext;
        key_d   = key;
        retry_d = '0;
        state_d = LAUNCH;
      end
      LAUNCH: begin
        done_lat_d = '0;
        tmo_d      = '0;
        state_d    = RUN;
      end
      RUN: begin
        for (int i = 0; i < NUM_LANES; i++) begin
          if (lane_done[i] && !done_lat_q[i]) begin
            done_lat_d[i] = 1'b1;
            ct_lat_d[i]   = lane_ct[i];
          end
        end
        tmo_d = tmo_q + 1'b1;
        // Completion wins over a timeout landing in the same cycle.
        if (&done_lat_d) begin
          state_d = CHECK;
        end else if (tmo_d == TMO_W'(TIMEOUT_CYC)) begin
          fault_ev = 1'b1;
          uncorr   = 1'b1;
        end
      end
      CHECK: begin
        result_d = vote_result;
        corr_d   = (vote == CORRECTED);
        if (vote == UNCORRECTABLE) begin
          fault_ev = 1'b1;
          uncorr   = 1'b1;
        end else begin
          fault_ev = (vote == CORRECTED);
          state_d  = HOLD;
        end
      end
      HOLD: if (out_ready) state_d = IDLE;
      default: state_d = LOCKED;
    endcase
    if (uncorr) begin
      if (retry_q < RTW'(RETRY_MAX)) begin
        retry_d = retry_q + 1'b1;
        state_d = LAUNCH;
      end else begin
        state_d = IDLE;
      end
    end
    if (fault_ev) begin
      if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
      // Lockout overrides delivery or retry of the request that hit the limit.
      if (cnt_d >= CNT_W'(FAULT_LIMIT)) state_d = LOCKED;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pt_q       <= '0;
      key_q      <= '0;
      result_q   <= '0;
      done_lat_q <= '0;
      ct_lat_q   <= '0;
      tmo_q      <= '0;
      retry_q    <= '0;
      cnt_q      <= '0;
      corr_q     <= 1'b0;
      alert_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pt_q       <= pt_d;
      key_q      <= key_d;
      result_q   <= result_d;
      done_lat_q <= done_lat_d;
      ct_lat_q   <= ct_lat_d;
      tmo_q      <= tmo_d;
      retry_q    <= retry_d;
      cnt_q      <= cnt_d;
      corr_q     <= corr_d;
      alert_q    <= fault_ev;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == HOLD);
  assign ciphertext  = out_valid ? result_q : '0;
  assign corrected   = out_valid & corr_q;
  assign fault_alert = alert_q;
  assign locked      = (state_q == LOCKED);
  assign busy        = (|lane_busy) | ~((state_q == IDLE) | (state_q == HOLD));
  assign fault_count = cnt_q;
endmodule

// File: doc/aes128_nmr_top.md
Name: aes128_nmr_top

Overview:
Parametrised N-modular-redundant AES-128 encryption top. It runs NUM_LANES aes128_core instances in lockstep and compares or majority-votes their results. On a mismatch it retries, and after repeated faults it locks out permanently until reset. It adds a ready/valid handshake on both input and output, a saturating fault counter, and suppresses ciphertext on any unverified result; it sits where the dual-lane hardened top sits today.

Parameters:
NUM_LANES, 3, redundant aes128_core lanes; legal values 2 (compare mode) or 3 (majority-vote mode)
RETRY_MAX, 2, re-computations allowed per request after an uncorrectable mismatch
FAULT_LIMIT, 8, total fault events that force LOCKED
TIMEOUT_CYC, 64, max cycles from start to all-lanes-done before a timeout fault
CNT_W, 8, width of fault_count

Ports:
clk  in  1  clock
rst_n  in  1  reset
in_valid  in  1  request valid
in_ready  out  1  block can accept request
plaintext  in  128  plaintext block
key  in  128  cipher key
inject_fault  in  NUM_LANES  per-lane fault injection to aes128_core.fault_inject
out_valid  out  1  verified ciphertext available
out_ready  in  1  consumer accepts ciphertext
ciphertext  out  128  verified result; all-zero when out_valid=0
corrected  out  1  with out_valid: result was majority-corrected (one lane outvoted)
fault_alert  out  1  one-cycle pulse per fault event
locked  out  1  permanent lockout
busy  out  1  any lane busy or FSM not IDLE/HOLD
fault_count  out  CNT_W  saturating total fault events
noise_activity  out  1  power_noise activity, enabled while busy

Behaviour:
- One clock. Reset is synchronous and active-low (rst_n sampled on the rising clk edge).
- Reset values:
  - State IDLE; in_ready=1; out_valid=0; ciphertext=0; corrected=0; fault_alert=0; locked=0; busy=0; fault_count=0.
  - All lane done/ciphertext latches are cleared.
  - Reset mid-operation aborts the request; no output is produced.
- FSM states are IDLE, LAUNCH, RUN, CHECK, HOLD and LOCKED.
  - IDLE: in_ready=1. On in_valid&in_ready, capture plaintext and key into internal registers and go to LAUNCH.
  - LAUNCH: pulse start to all lanes for one cycle, using the captured operands. Clear the per-lane done latches and the timeout counter. Go to RUN.
  - RUN: latch each lane's ciphertext on the first cycle its done is high.
    - When all lanes are latched, go to CHECK.
    - If the timeout counter reaches TIMEOUT_CYC first, that is a fault event; treat it as an uncorrectable mismatch.
  - CHECK, single cycle, evaluated by the voter:
    - All lanes equal: result = lane0, corrected=0, go to HOLD.
    - NUM_LANES=3 with exactly two lanes equal: result = the majority value, corrected=1, one fault event, go to HOLD.
    - Otherwise (uncorrectable): one fault event. If retry count < RETRY_MAX, increment it and go to LAUNCH; else go to IDLE, dropping the request without out_valid.
  - HOLD: out_valid=1 and ciphertext=result. Both stay stable until out_ready. On out_valid&out_ready, go to IDLE with ciphertext=0.
  - LOCKED: in_ready=0, out_valid=0, ciphertext=0, locked=1. Only reset exits this state.
- Retry count resets to 0 on each accepted request.
- Fault events:
  - Each event pulses fault_alert for one cycle and increments fault_count, saturating at 2^CNT_W-1.
  - When fault_count reaches FAULT_LIMIT, the next state is LOCKED. This has priority over HOLD and LAUNCH, so a corrected result at the limit is not delivered.
- in_ready=0 in every state except IDLE; new requests are never queued.
- inject_fault is passed through combinationally to the lanes.
- power_noise: enable=busy, seed = captured key[31:0] ^ captured plaintext[127:96].
- Simultaneous events:
  - A timeout and the last done in the same cycle count as done (no timeout).
  - A fault event and reaching the limit in the same cycle produce one increment and one pulse.
- Latency, fault-free: accept edge, then LAUNCH (1) + core latency + CHECK (1), then out_valid.

Decomposition:
- Package aes_nmr_pkg holds:
  - state_t enum: IDLE, LAUNCH, RUN, CHECK, HOLD, LOCKED.
  - vote_t enum: AGREE, CORRECTED, UNCORRECTABLE.
  - AES_BLK_W = 128 constant.
- One combinational sub-module, aes_nmr_voter:
  - Inputs: NUM_LANES latched ciphertexts.
  - Outputs: vote_t and the 128-bit result.
  - Instantiated once.
- Existing aes128_core and power_noise are reused unchanged.

Test Plan:
- FIPS-197 vector, no faults, out_ready=1: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> out_valid with ct 69c4e0d86a7b0430d8cdb78070b4c55a, corrected=0, fault_count=0.
- NUM_LANES=3, inject_fault=3'b010 on the same vector -> correct ct with corrected=1, one fault_alert pulse, fault_count=1.
- NUM_LANES=2, inject_fault=2'b10 held, RETRY_MAX=2 -> 3 fault pulses, no out_valid, returns to IDLE, fault_count=3, ciphertext stays 0.
- Backpressure: out_ready=0 for 10 cycles after out_valid -> ciphertext stable, in_ready=0 throughout; out_ready=1 -> IDLE next cycle, ciphertext=0.
- FAULT_LIMIT=4, repeated faulty requests -> locked=1 after the 4th event, in_ready=0, further in_valid ignored; rst_n=0 for one clock -> all outputs back to reset values.
- Reset asserted mid-RUN -> no out_valid or fault_alert afterwards, state IDLE; the next fault-free request produces correct ct.
